// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Purpose  : Pipelined RV32I control unit. Decodes the D-stage instruction
//            and carries its control fields through the E, M and W stages.
//            Supports flush and bubble insertion. A multi-cycle MDU
//            occupancy FSM stalls the front end while a mul/div is in E.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   PIPE_CTRL_MEXT_EN - when defined, decodes the RV32M subset
//                       (mul, mulh, div, rem) and enables the MDU FSM.
//                       When undefined, func7=0000001 encodings are illegal
//                       and stallD, mdu_startE and mdu_busy are tied to 0.
// ----------------------------------------------------------------------------
// Parameters:
//   ALUC_W  - AluControlE width (>=4); ALU codes are zero-extended
//   MUL_LAT - E-stage occupancy in cycles for mul/mulh (>=1)
//   DIV_LAT - E-stage occupancy in cycles for div/rem (>=1)
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   OPC, func3, func7        - D-stage instruction fields
//   instr_valid              - D-stage instruction is valid
//   flushE                   - load a bubble into E
//   ImmSrcD                  - combinational immediate-type select
//   *E / *M / *W             - registered stage controls
//   illegalE                 - the E-stage instruction was undecodable
//   stallD, mdu_busy         - MDU stall request to F/D (identical)
//   mdu_startE               - one pulse per MDU instruction in E
// ============================================================================
module pipe_ctrl_unit #(
  parameter int ALUC_W  = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        OPC,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic              instr_valid,
  input  logic              flushE,
  output logic [2:0]        ImmSrcD,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic [1:0]        JumpE,
  output logic [2:0]        BranchE,
  output logic [1:0]        ResultSrcE,
  output logic [ALUC_W-1:0] AluControlE,
  output logic              illegalE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic              stallD,
  output logic              mdu_startE,
  output logic              mdu_busy
);

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_B    = 7'b1100011;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;

  // Parameter sanity check at elaboration.
  if (ALUC_W < 4 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
    $error("pipe_ctrl_unit: illegal parameter value");
  end

  typedef struct packed {
    logic              regwrite;
    logic              memwrite;
    logic              alusrc;
    logic [1:0]        jump;
    logic [2:0]        branch;
    logic [1:0]        resultsrc;
    logic [ALUC_W-1:0] aluctl;
    logic              illegal;
  } ctl_e_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
  } ctl_m_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
  } ctl_w_t;

  ctl_e_t     w_dec;
  logic [3:0] w_alu4;
  logic [2:0] w_imm;
  logic       w_ill;
  logic       w_stall;
  logic       w_start;

  ctl_e_t r_e;
  ctl_m_t r_m;
  ctl_w_t r_w;

`ifdef PIPE_CTRL_MEXT_EN
  logic w_mdu;
  logic w_div;
  logic r_mdu_e;
  logic r_div_e;
`endif

  // --------------------------------------------------------------------------
  // D-stage decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec  = '0;
    w_alu4 = 4'd0;
    w_imm  = 3'b000;
    w_ill  = 1'b0;
`ifdef PIPE_CTRL_MEXT_EN
    w_mdu  = 1'b0;
    w_div  = 1'b0;
`endif
    case (OPC)
      c_OP_R: begin
        w_dec.regwrite = 1'b1;
        if (func7 == 7'b0000000) begin
          case (func3)
            3'b000:  w_alu4 = 4'd0;   // add
            3'b111:  w_alu4 = 4'd2;   // and
            3'b110:  w_alu4 = 4'd3;   // or
            3'b010:  w_alu4 = 4'd5;   // slt
            3'b011:  w_alu4 = 4'd6;   // sltu
            3'b100:  w_alu4 = 4'd7;   // xor
            3'b001:  w_alu4 = 4'd8;   // sll
            default: w_alu4 = 4'd9;   // srl (3'b101)
          endcase
        end else if (func7 == 7'b0100000) begin
          case (func3)
            3'b000:  w_alu4 = 4'd1;   // sub
            3'b101:  w_alu4 = 4'd10;  // sra
            default: w_ill  = 1'b1;
          endcase
`ifdef PIPE_CTRL_MEXT_EN
        end else if (func7 == 7'b0000001) begin
          w_mdu = 1'b1;
          case (func3)
            3'b000:  w_alu4 = 4'd11;                  // mul
            3'b001:  w_alu4 = 4'd12;                  // mulh
            3'b100:  begin w_alu4 = 4'd13; w_div = 1'b1; end  // div
            3'b110:  begin w_alu4 = 4'd14; w_div = 1'b1; end  // rem
            default: w_ill  = 1'b1;
          endcase
`endif
        end else begin
          w_ill = 1'b1;
        end
      end
      c_OP_I: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        case (func3)
          3'b000: w_alu4 = 4'd0;   // addi
          3'b111: w_alu4 = 4'd2;   // andi
          3'b110: w_alu4 = 4'd3;   // ori
          3'b010: w_alu4 = 4'd5;   // slti
          3'b011: w_alu4 = 4'd6;   // sltiu
          3'b100: w_alu4 = 4'd7;   // xori
          3'b001: begin            // slli: func7 is part of the encoding
            w_alu4 = 4'd8;
            w_ill  = (func7 != 7'b0000000);
          end
          default: begin           // srli / srai
            if (func7 == 7'b0000000)      w_alu4 = 4'd9;
            else if (func7 == 7'b0100000) w_alu4 = 4'd10;
            else                          w_ill  = 1'b1;
          end
        endcase
      end
      c_OP_LW: begin
        w_dec.regwrite  = 1'b1;
        w_dec.alusrc    = 1'b1;
        w_dec.resultsrc = 2'b01;
      end
      c_OP_SW: begin
        w_dec.memwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_imm          = 3'b001;
        w_ill          = (func3 != 3'b010);
      end
      c_OP_B: begin
        w_imm  = 3'b010;
        w_alu4 = 4'd1;
        case (func3)
          3'b000:  w_dec.branch = 3'b001;  // beq
          3'b001:  w_dec.branch = 3'b010;  // bne
          3'b100:  w_dec.branch = 3'b011;  // blt
          3'b101:  w_dec.branch = 3'b100;  // bge
          default: w_ill        = 1'b1;
        endcase
      end
      c_OP_LUI: begin
        w_dec.regwrite  = 1'b1;
        w_dec.alusrc    = 1'b1;
        w_dec.resultsrc = 2'b11;
        w_imm           = 3'b011;
        w_alu4          = 4'd4;
      end
      c_OP_JAL: begin
        w_dec.regwrite  = 1'b1;
        w_dec.alusrc    = 1'b1;
        w_dec.resultsrc = 2'b11;
        w_dec.jump      = 2'b01;
        w_imm           = 3'b100;
      end
      c_OP_JALR: begin
        w_dec.regwrite  = 1'b1;
        w_dec.alusrc    = 1'b1;
        w_dec.resultsrc = 2'b11;
        w_dec.jump      = 2'b10;
        w_ill           = (func3 != 3'b000);
      end
      default: w_ill = 1'b1;
    endcase

    // An undecodable instruction carries no controls, only the illegal flag.
    if (w_ill) begin
      w_dec  = '0;
      w_alu4 = 4'd0;
      w_imm  = 3'b000;
`ifdef PIPE_CTRL_MEXT_EN
      w_mdu  = 1'b0;
      w_div  = 1'b0;
`endif
    end
    w_dec.aluctl  = ALUC_W'(w_alu4);
    w_dec.illegal = w_ill;
  end

  assign ImmSrcD = w_imm;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_e <= '0;
    else if (flushE)      r_e <= '0;
    else if (w_stall)     r_e <= r_e;
    else if (instr_valid) r_e <= w_dec;
    else                  r_e <= '0;
  end

  // While the MDU holds E, M receives bubbles so nothing is issued twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_m <= '0;
    else if (w_stall) r_m <= '0;
    else              r_m <= '{regwrite: r_e.regwrite, memwrite: r_e.memwrite,
                               resultsrc: r_e.resultsrc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_w <= '0;
    else     r_w <= '{regwrite: r_m.regwrite, resultsrc: r_m.resultsrc};
  end

`ifdef PIPE_CTRL_MEXT_EN
  // --------------------------------------------------------------------------
  // MDU occupancy FSM
  // --------------------------------------------------------------------------
  localparam int                 c_CNT_W    = $clog2(DIV_LAT) + 1;
  localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(MUL_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(DIV_LAT - 1);
  localparam logic [0:0]         c_IDLE     = 1'b0;
  localparam logic [0:0]         c_BUSY     = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_last;

  // The MDU flags follow the E register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mdu_e <= 1'b0;
      r_div_e <= 1'b0;
    end else if (flushE) begin
      r_mdu_e <= 1'b0;
      r_div_e <= 1'b0;
    end else if (w_stall) begin
      r_mdu_e <= r_mdu_e;
      r_div_e <= r_div_e;
    end else if (instr_valid) begin
      r_mdu_e <= w_mdu;
      r_div_e <= w_div;
    end else begin
      r_mdu_e <= 1'b0;
      r_div_e <= 1'b0;
    end
  end

  assign w_last = r_div_e ? c_DIV_LAST : c_MUL_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A flush aborts the operation; otherwise count while stalling and
  // return to idle on the cycle the instruction is released.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flushE) begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_stall) begin
      w_state_nxt = c_BUSY;
      w_cnt_nxt   = r_cnt + c_CNT_W'(1);
    end else begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_comb begin
    w_stall = r_mdu_e && (r_cnt != w_last);
    w_start = r_mdu_e && (r_state == c_IDLE);
  end
`else
  assign w_stall = 1'b0;
  assign w_start = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign RegWriteE   = r_e.regwrite;
  assign MemWriteE   = r_e.memwrite;
  assign ALUSrcE     = r_e.alusrc;
  assign JumpE       = r_e.jump;
  assign BranchE     = r_e.branch;
  assign ResultSrcE  = r_e.resultsrc;
  assign AluControlE = r_e.aluctl;
  assign illegalE    = r_e.illegal;
  assign RegWriteM   = r_m.regwrite;
  assign MemWriteM   = r_m.memwrite;
  assign ResultSrcM  = r_m.resultsrc;
  assign RegWriteW   = r_w.regwrite;
  assign ResultSrcW  = r_w.resultsrc;
  assign stallD      = w_stall;
  assign mdu_busy    = w_stall;
  assign mdu_startE  = w_start;

endmodule
`default_nettype wire
